branch_resolver: RTL and testbench
==================================

# branch_resolver

Write-side partner of the branch target buffer. It carries each fetched PC and its IF-stage prediction (pred_take, pred_pc) through IF/ID and ID/EX shadow registers. In EX it compares the prediction with the resolved outcome, drives the pipeline flush/redirect, and issues the single BTB update for that instruction. It also keeps saturating branch and mispredict counters for performance reporting.

## Interface
- COUNTER_WIDTH, 32, width of each performance counter.
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-high; sampled on the rising edge of clk.
- pc_IF  input  32  PC being fetched this cycle.
- pred_take_IF  input  1  BTB hit/predict-taken for pc_IF.
- pred_pc_IF  input  32  BTB predicted target for pc_IF.
- stall_ID  input  1  load-use stall: hold IF/ID, bubble into ID/EX.
- stall_EX  input  1  back-end stall: hold both shadow stages, suppress all EX actions.
- br_EX  input  1  instruction in EX is a conditional branch or jump.
- br_taken_EX  input  1  resolved direction; ignored unless br_EX.
- br_target_EX  input  32  resolved target; ignored unless br_EX.
- flush  output  1  kill IF/ID and ID/EX contents; combinational.
- redirect_pc  output  32  next fetch PC when flush=1.
- btb_wr_en, btb_wr_pc[31:0], btb_taken, btb_target[31:0], btb_pred_take_EX  output  BTB update port.
- branch_cnt  output  COUNTER_WIDTH  resolved branches.
- mispred_cnt  output  COUNTER_WIDTH  mispredictions.

## Operation
- Each shadow stage holds the fields {valid, pc, pred_take, pred_pc}.
- Stage update priority on each clock edge is rst > flush > stall_EX > stall_ID > advance.
  - rst: clears both stages (valid=0, other fields 0) and both counters.
  - flush: clears valid in both stages.
  - stall_EX: holds both stages.
  - stall_ID: holds IF/ID; ID/EX loads valid=0.
  - advance: IF/ID loads {1, pc_IF, pred_take_IF, pred_pc_IF}; ID/EX loads IF/ID.
- Define act = ex.valid & !stall_EX. Define taken = br_EX & br_taken_EX.
- mispredict = act & (br_EX | ex.pred_take) & one of:
  - taken != ex.pred_take, or
  - taken & ex.pred_take & (br_target_EX != ex.pred_pc).
- A non-branch with pred_take=1 (aliased entry) counts as a mispredict with taken=0.
- flush = mispredict.
- redirect_pc = taken ? br_target_EX : ex.pc + 4. Addition is modulo 2^32; the wrap 0xFFFFFFFC→0 is legal.
- BTB update fields:
  - btb_wr_en = act & (br_EX | ex.pred_take).
  - btb_wr_pc = ex.pc.
  - btb_taken = taken.
  - btb_target = br_target_EX.
  - btb_pred_take_EX = ex.pred_take.
- Counters:
  - branch_cnt increments when act & br_EX.
  - mispred_cnt increments when mispredict.
  - Both saturate at all-ones.

## Timing
- Reset values: all outputs 0; both counters 0; both stages invalid. The first valid EX entry appears no earlier than edge 2 after rst deasserts.
- A prediction sampled at IF on edge N is visible in EX during cycle N+2, given no stalls.
- flush, redirect_pc and btb_* are combinational from the ID/EX stage and EX inputs, valid in the same cycle. The flush takes effect on the next edge.
- Exactly one btb_wr_en pulse per EX instruction, issued in the cycle it leaves EX. While stall_EX=1 the outputs stay 0; the pulse fires on the first unstalled cycle.
- Counters update on the edge after the qualifying cycle.
- flush together with stall_ID: flush wins, both stages are invalid.
- rst mid-operation: stages and counters clear on that edge, and no update is issued in the reset cycle.

## Structure
- Package branch_pkg:
  - typedef pred_entry_t (struct of valid, pc, pred_take, pred_pc);
  - localparam PRED_ENTRY_NOP (all zero);
  - localparam INSTR_BYTES = 4.
- Sub-module pred_pipe_reg: one shadow stage with inputs d, hold, bubble, clear. Instantiated twice, for IF/ID and ID/EX.
- The top contains the compare/redirect logic and the two saturating counters.

## Test plan
1. Correct taken prediction: pc 0x100, pred_take=1, pred_pc=0x200; EX br_EX=1, taken=1, target=0x200.
   - Required: flush=0, one btb_wr_en with btb_taken=1; branch_cnt=1, mispred_cnt=0.
2. Not predicted but taken: pc 0x104, pred_take=0; EX taken, target=0x40.
   - Required: flush=1, redirect_pc=0x40, btb_wr_en=1, btb_pred_take_EX=0; both younger stages invalid next cycle; mispred_cnt=1.
3. Predicted taken but not taken: pc 0x108, pred_take=1; EX br_EX=1, taken=0.
   - Required: flush=1, redirect_pc=0x10C, btb_taken=0.
4. Aliased non-branch: pc 0xFFFFFFFC, pred_take=1, br_EX=0.
   - Required: flush=1, redirect_pc=0x0, branch_cnt unchanged.
5. Stalls: stall_EX held 3 cycles on a mispredicting branch.
   - Required: no flush or btb_wr_en while stalled; exactly one of each on release.
   - Also: stall_ID for 1 cycle inserts one invalid EX cycle (btb_wr_en=0).
6. Reset and saturation: rst asserted mid-flush.
   - Required: outputs 0 next cycle.
   - With COUNTER_WIDTH=2: 5 mispredicts leave mispred_cnt=3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver: the shadow-stage
// prediction record carried from IF to EX.
package branch_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_take;
        logic [31:0] pred_pc;
    } pred_entry_t;

    localparam pred_entry_t PRED_ENTRY_NOP = '{
        valid:     1'b0,
        pc:        32'h0000_0000,
        pred_take: 1'b0,
        pred_pc:   32'h0000_0000
    };

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/branch_resolver_pipe_reg.sv
// One shadow pipeline stage holding a fetched PC and its prediction.
// Priority: rst > clear > hold > bubble > load.
module pred_pipe_reg
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pred_entry_t d,
    input  logic        hold,
    input  logic        bubble,
    input  logic        clear,
    output pred_entry_t q
);

    pred_entry_t entry_q;
    pred_entry_t entry_d;

    // next-state selection for the stage
    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d.valid = 1'b0;
        end else if (hold) begin
            entry_d = entry_q;
        end else if (bubble) begin
            entry_d = PRED_ENTRY_NOP;
        end else begin
            entry_d = d;
        end
    end

    // stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= PRED_ENTRY_NOP;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/branch_resolver.sv
// Resolves IF-stage predictions in EX: drives flush/redirect, issues the BTB
// update and keeps saturating branch/mispredict counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_IF,
    input  logic                     pred_take_IF,
    input  logic [31:0]              pred_pc_IF,
    input  logic                     stall_ID,
    input  logic                     stall_EX,
    input  logic                     br_EX,
    input  logic                     br_taken_EX,
    input  logic [31:0]              br_target_EX,
    output logic                     flush,
    output logic [31:0]              redirect_pc,
    output logic                     btb_wr_en,
    output logic [31:0]              btb_wr_pc,
    output logic                     btb_taken,
    output logic [31:0]              btb_target,
    output logic                     btb_pred_take_EX,
    output logic [COUNTER_WIDTH-1:0] branch_cnt,
    output logic [COUNTER_WIDTH-1:0] mispred_cnt
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    pred_entry_t if_entry_s;
    pred_entry_t id_q;
    pred_entry_t ex_q;

    logic act_s;
    logic taken_s;
    logic touch_s;
    logic wrong_s;
    logic mispred_s;

    logic [COUNTER_WIDTH-1:0] branch_cnt_q;
    logic [COUNTER_WIDTH-1:0] branch_cnt_d;
    logic [COUNTER_WIDTH-1:0] mispred_cnt_q;
    logic [COUNTER_WIDTH-1:0] mispred_cnt_d;

    // fetch-side record entering IF/ID
    always_comb begin
        if_entry_s = '{valid: 1'b1, pc: pc_IF, pred_take: pred_take_IF, pred_pc: pred_pc_IF};
    end

    pred_pipe_reg u_if_id (
        .clk    (clk),
        .rst    (rst),
        .d      (if_entry_s),
        .hold   (stall_EX | stall_ID),
        .bubble (1'b0),
        .clear  (mispred_s),
        .q      (id_q)
    );

    pred_pipe_reg u_id_ex (
        .clk    (clk),
        .rst    (rst),
        .d      (id_q),
        .hold   (stall_EX),
        .bubble (stall_ID),
        .clear  (mispred_s),
        .q      (ex_q)
    );

    // EX compare; rst also blocks actions so nothing leaks out of the reset cycle
    always_comb begin
        act_s     = ex_q.valid & ~stall_EX & ~rst;
        taken_s   = br_EX & br_taken_EX;
        touch_s   = act_s & (br_EX | ex_q.pred_take);
        wrong_s   = (taken_s != ex_q.pred_take)
                  | (taken_s & ex_q.pred_take & (br_target_EX != ex_q.pred_pc));
        mispred_s = touch_s & wrong_s;
    end

    // flush/redirect and BTB update port, zeroed when idle
    always_comb begin
        flush            = mispred_s;
        redirect_pc      = 32'h0000_0000;
        btb_wr_en        = touch_s;
        btb_wr_pc        = 32'h0000_0000;
        btb_taken        = 1'b0;
        btb_target       = 32'h0000_0000;
        btb_pred_take_EX = 1'b0;
        if (mispred_s) begin
            redirect_pc = taken_s ? br_target_EX : (ex_q.pc + INSTR_BYTES);
        end else begin
            redirect_pc = 32'h0000_0000;
        end
        if (touch_s) begin
            btb_wr_pc        = ex_q.pc;
            btb_taken        = taken_s;
            btb_target       = br_target_EX;
            btb_pred_take_EX = ex_q.pred_take;
        end else begin
            btb_wr_pc        = 32'h0000_0000;
        end
    end

    // saturating counter next values
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (act_s && br_EX && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (mispred_s && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed instructions push the
// expected BTB update; a negedge monitor pops and compares on each pulse.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_IF;
    logic        pred_take_IF;
    logic [31:0] pred_pc_IF;
    logic        stall_ID;
    logic        stall_EX;
    logic        br_EX;
    logic        br_taken_EX;
    logic [31:0] br_target_EX;

    logic        flush;
    logic [31:0] redirect_pc;
    logic        btb_wr_en;
    logic [31:0] btb_wr_pc;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        btb_pred_take_EX;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    logic        s_flush;
    logic [31:0] s_redirect_pc;
    logic        s_btb_wr_en;
    logic [31:0] s_btb_wr_pc;
    logic        s_btb_taken;
    logic [31:0] s_btb_target;
    logic        s_btb_pred_take_EX;
    logic [1:0]  s_branch_cnt;
    logic [1:0]  s_mispred_cnt;

    typedef struct {
        logic        flush;
        logic [31:0] redirect_pc;
        logic [31:0] wr_pc;
        logic        taken;
        logic [31:0] target;
        logic        pred_take;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolver #(.COUNTER_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc_IF(pc_IF), .pred_take_IF(pred_take_IF),
        .pred_pc_IF(pred_pc_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .br_EX(br_EX), .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
        .flush(flush), .redirect_pc(redirect_pc), .btb_wr_en(btb_wr_en),
        .btb_wr_pc(btb_wr_pc), .btb_taken(btb_taken), .btb_target(btb_target),
        .btb_pred_take_EX(btb_pred_take_EX), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    branch_resolver #(.COUNTER_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .pc_IF(pc_IF), .pred_take_IF(pred_take_IF),
        .pred_pc_IF(pred_pc_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .br_EX(br_EX), .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
        .flush(s_flush), .redirect_pc(s_redirect_pc), .btb_wr_en(s_btb_wr_en),
        .btb_wr_pc(s_btb_wr_pc), .btb_taken(s_btb_taken), .btb_target(s_btb_target),
        .btb_pred_take_EX(s_btb_pred_take_EX), .branch_cnt(s_branch_cnt),
        .mispred_cnt(s_mispred_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every BTB pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (btb_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_btb_wr_en", {31'd0, btb_wr_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("flush", {31'd0, flush}, {31'd0, e.flush});
                if (e.flush) check("redirect_pc", redirect_pc, e.redirect_pc);
                check("btb_wr_pc", btb_wr_pc, e.wr_pc);
                check("btb_taken", {31'd0, btb_taken}, {31'd0, e.taken});
                check("btb_target", btb_target, e.target);
                check("btb_pred_take_EX", {31'd0, btb_pred_take_EX}, {31'd0, e.pred_take});
            end
        end else begin
            check("flush_without_wr", {31'd0, flush}, 32'd0);
        end
    end

    task automatic idle_if();
        pc_IF = 32'h0000_1000; pred_take_IF = 1'b0; pred_pc_IF = 32'h0;
    endtask

    task automatic clear_ex();
        br_EX = 1'b0; br_taken_EX = 1'b0; br_target_EX = 32'h0;
    endtask

    // one instruction from IF to EX; entered and left at posedge+1
    task automatic run_instr(input logic [31:0] pc, input logic pt, input logic [31:0] ppc,
                             input logic br, input logic tk, input logic [31:0] tgt,
                             input logic exp_flush, input logic [31:0] exp_redir,
                             input int stall_ex_cycles, input bit stall_id_once);
        exp_t e;
        pc_IF = pc; pred_take_IF = pt; pred_pc_IF = ppc;
        @(posedge clk); #1;
        idle_if();
        if (stall_id_once) begin
            stall_ID = 1'b1;
            @(posedge clk); #1;
            stall_ID = 1'b0;
            br_EX = 1'b1; br_taken_EX = 1'b1; br_target_EX = 32'h0000_0BAD;
            @(negedge clk);
            check("bubble_no_wr", {31'd0, btb_wr_en}, 32'd0);
        end
        @(posedge clk); #1;
        br_EX = br; br_taken_EX = tk; br_target_EX = tgt;
        if (stall_ex_cycles > 0) begin
            stall_EX = 1'b1;
            for (int i = 0; i < stall_ex_cycles; i++) begin
                @(negedge clk);
                check("stall_no_flush", {31'd0, flush}, 32'd0);
                check("stall_no_wr", {31'd0, btb_wr_en}, 32'd0);
                @(posedge clk); #1;
            end
            stall_EX = 1'b0;
        end
        e.flush = exp_flush; e.redirect_pc = exp_redir; e.wr_pc = pc;
        e.taken = br & tk; e.target = tgt; e.pred_take = pt;
        if (br | pt) exp_q.push_back(e);
        @(posedge clk); #1;
        clear_ex();
        if (exp_flush) begin
            // younger stages were killed: a branch here must produce nothing
            br_EX = 1'b1; br_taken_EX = 1'b1; br_target_EX = 32'h0000_0BAD;
            repeat (2) @(posedge clk);
            #1;
            clear_ex();
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mis);
        @(negedge clk);
        check({tag, "_branch_cnt"}, branch_cnt, exp_br);
        check({tag, "_mispred_cnt"}, mispred_cnt, exp_mis);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; stall_ID = 1'b0; stall_EX = 1'b0;
        idle_if(); clear_ex();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_wr_en", {31'd0, btb_wr_en}, 32'd0);
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);
        @(posedge clk); #1;

        // correct taken prediction
        run_instr(32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 0, 1'b0);
        check_cnt("t1", 32'd1, 32'd0);
        // taken but not predicted
        run_instr(32'h104, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 0, 1'b0);
        check_cnt("t2", 32'd2, 32'd1);
        // predicted taken, not taken
        run_instr(32'h108, 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, 1'b1, 32'h10C, 0, 1'b0);
        check_cnt("t3", 32'd3, 32'd2);
        // aliased non-branch at the top of the address space
        run_instr(32'hFFFF_FFFC, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b0);
        check_cnt("t4", 32'd3, 32'd3);
        // mispredict held three cycles by stall_EX
        run_instr(32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 3, 1'b0);
        check_cnt("t5", 32'd4, 32'd4);
        // one-cycle stall_ID bubble ahead of a correct prediction
        run_instr(32'h300, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 0, 1'b1);
        check_cnt("t6", 32'd5, 32'd4);
        // direction right, target wrong
        run_instr(32'h400, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b1, 32'h600, 0, 1'b0);
        check_cnt("t7", 32'd6, 32'd5);
        @(negedge clk);
        check("sat_mispred_cnt", {30'd0, s_mispred_cnt}, 32'd3);
        check("sat_branch_cnt", {30'd0, s_branch_cnt}, 32'd3);
        @(posedge clk); #1;

        // reset asserted while a mispredict sits in EX
        pc_IF = 32'h500; pred_take_IF = 1'b0; pred_pc_IF = 32'h0;
        @(posedge clk); #1;
        idle_if();
        @(posedge clk); #1;
        br_EX = 1'b1; br_taken_EX = 1'b1; br_target_EX = 32'h700;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_ex();
        @(negedge clk);
        check("post_rst_flush", {31'd0, flush}, 32'd0);
        check("post_rst_redirect", redirect_pc, 32'd0);
        check("post_rst_wr_en", {31'd0, btb_wr_en}, 32'd0);
        check("post_rst_wr_pc", btb_wr_pc, 32'd0);
        check("post_rst_branch_cnt", branch_cnt, 32'd0);
        check("post_rst_mispred_cnt", mispred_cnt, 32'd0);
        check("post_rst_sat_mispred", {30'd0, s_mispred_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
